sprite_sheet_loader: RTL and testbench
======================================

// Module: sprite_sheet_loader
// PURPOSE
//  Write side of the sprite-sheet frameRAM. color_mapper reads 4-bit palette IDs from this RAM.
//  This block fills it at boot or level change from a run-length-encoded byte stream (SRAM/NIOS feed).
//  Expands each run into sequential frameRAM writes, row-major, starting at address 0.
//  Drives frameRAM write_address/data_In/we; reads are untouched.
// PARAMETERS
//  NUM_PIXELS  40000  total sheet pixels (200x200); last address = NUM_PIXELS-1
//  ADDR_W      16     frameRAM address width
// PORTS
//  Clk            in   1       system clock; all state on rising edge
//  Reset_n        in   1       asynchronous, active-low reset
//  start          in   1       1-cycle pulse: begin a load at address 0
//  in_data        in   8       RLE byte {run[7:4], pal[3:0]}; writes pal run+1 times (1..16)
//  in_valid       in   1       in_data valid
//  in_ready       out  1       loader accepts in_data this cycle
//  write_address  out  ADDR_W  frameRAM write address
//  data_In        out  4       palette ID to write
//  we             out  1       frameRAM write enable
//  busy           out  1       load in progress
//  done           out  1       1-cycle pulse: last pixel written
//  loaded         out  1       sheet fully loaded (level); cleared by start
//  err_overrun    out  1       sticky: final run exceeded NUM_PIXELS; cleared by start
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE.
//   All outputs 0: in_ready, we, busy, done, loaded, err_overrun, write_address, data_In.
//  FSM states: IDLE, FETCH, WRITE, FINISH.
//  IDLE: start=1 -> FETCH.
//   On that edge: addr=0, loaded=0, err_overrun=0.
//  FETCH: in_ready=1, we=0.
//   in_valid&in_ready -> WRITE; latch pal=in_data[3:0], left=in_data[7:4].
//   Otherwise stay in FETCH; no timeout.
//  WRITE: we=1, write_address=addr, data_In=pal, in_ready=0.
//   If addr==NUM_PIXELS-1 -> FINISH. If left!=0 at that point, set err_overrun and drop the rest of the run.
//   Else if left==0 -> FETCH, addr+=1.
//   Else left-=1, addr+=1, stay in WRITE.
//  FINISH: done=1 for exactly 1 cycle, loaded=1 (held), -> IDLE.
//  busy=1 in FETCH/WRITE/FINISH.
//  Timing: byte accepted at edge N -> first we=1 in cycle N+1.
//   A run of k pixels occupies k WRITE cycles, then 1 FETCH cycle minimum.
//  Addresses strictly increment by 1 and never wrap; no write ever goes to address >= NUM_PIXELS.
//  start while busy: ignored, no restart.
//  in_valid while in_ready=0: byte not consumed; source holds it.
//  Extra bytes after FINISH are never accepted (in_ready=0 in IDLE).
//  Reset mid-load: immediate abort. we drops asynchronously; loaded=0. frameRAM contents are undefined-partial.
//  addr is ADDR_W wide, unsigned. left is 4 bits.
// TESTING
//  1. Reset then start. Feed 2500 bytes of 0xF3 (16 px of pal 3), in_valid held 1.
//     -> 40000 writes of data_In=3 at addr 0..39999; done pulses once; loaded=1; err_overrun=0.
//  2. Stream 0x20,0x05,... ->
//     we at addr 0,1,2 with data 0; then addr 3 with data 5.
//     Exactly 1 FETCH cycle (we=0, in_ready=1) between the runs.
//  3. Feed runs totalling 39998 px, then 0x47 (5 px).
//     -> writes at 39998,39999 only; err_overrun=1; done=1; no addr>=40000.
//  4. Toggle in_valid randomly (50%); compare a RAM model against the golden expansion.
//     -> exact match; no byte consumed while in_ready=0.
//  5. Assert start mid-load (addr~1000).
//     -> ignored; the load completes normally; done pulses once.
//  6. Pull Reset_n low mid-WRITE.
//     -> we, busy, loaded drop without a clock edge. A new start reloads from addr 0.

Source files
------------

// File: rtl/sprite_sheet_loader.sv
// Expands an RLE byte stream {run[7:4], pal[3:0]} into sequential frameRAM writes from address 0.
// Latency: byte accepted at edge N gives first write in cycle N+1; in_ready only in FETCH.
module sprite_sheet_loader #(
  parameter int NUM_PIXELS = 40000,
  parameter int ADDR_W     = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] write_address,
  output logic [3:0]        data_In,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              loaded,
  output logic              err_overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, FINISH} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        left;

  // data_In doubles as the latched palette ID of the current run.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      addr          <= '0;
      left          <= '0;
      in_ready      <= 1'b0;
      write_address <= '0;
      data_In       <= '0;
      we            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      loaded        <= 1'b0;
      err_overrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            addr        <= '0;
            loaded      <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b1;
            in_ready    <= 1'b1;
          end
        end
        FETCH: begin
          if (in_valid && in_ready) begin
            state         <= WRITE;
            left          <= in_data[7:4];
            data_In       <= in_data[3:0];
            write_address <= addr;
            we            <= 1'b1;
            in_ready      <= 1'b0;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            // Last pixel of the sheet: any remainder of the run is discarded.
            state  <= FINISH;
            we     <= 1'b0;
            done   <= 1'b1;
            loaded <= 1'b1;
            if (left != 4'd0)
              err_overrun <= 1'b1;
          end else if (left == 4'd0) begin
            state    <= FETCH;
            we       <= 1'b0;
            in_ready <= 1'b1;
            addr     <= addr + 1'b1;
          end else begin
            left          <= left - 4'd1;
            addr          <= addr + 1'b1;
            write_address <= addr + 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_sheet_loader.sv
// Scoreboard bench: expected frameRAM writes are queued from the byte stream, a negedge monitor pops and compares.
module tb_sprite_sheet_loader;

  localparam int NP = 40000;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] write_address;
  logic [3:0]  data_In;
  logic        we, busy, done, loaded, err_overrun;

  sprite_sheet_loader #(.NUM_PIXELS(NP), .ADDR_W(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .write_address(write_address), .data_In(data_In), .we(we),
    .busy(busy), .done(done), .loaded(loaded), .err_overrun(err_overrun)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  pal;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  m_addr = 0;
  bit  m_over = 1'b0;

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge Clk) begin
    wr_t e;
    if (done) done_cnt++;
    if (we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write", write_address, data_In);
      end else begin
        e = exp_q.pop_front();
        if (write_address !== e.addr || data_In !== e.pal || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%0d in_ready=%0b, expected addr=%0d data=%0d in_ready=0",
                   write_address, data_In, in_ready, e.addr, e.pal);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Golden expansion of one RLE byte into the expected write queue.
  task automatic push_byte(input logic [7:0] b);
    wr_t e;
    for (int k = 0; k <= int'(b[7:4]); k++) begin
      if (m_addr < NP) begin
        e.addr = 16'(m_addr);
        e.pal  = b[3:0];
        exp_q.push_back(e);
        m_addr++;
      end else begin
        m_over = 1'b1;
      end
    end
  endtask

  // Present a byte until consumed; decisions are made at negedge so the accepting posedge is known.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit ok = 1'b0;
    push_byte(b);
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      in_data  = b;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid && in_ready) begin
        @(posedge Clk);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %02h not consumed, expected acceptance within 400 cycles", b);
    end
  endtask

  task automatic idle_src();
    @(negedge Clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  logic [7:0] rnd_tab [16] = '{8'h1A, 8'h07, 8'hF2, 8'h3C, 8'h00, 8'h59, 8'h21, 8'hE4,
                                8'h0F, 8'h76, 8'h18, 8'hC0, 8'h35, 8'h0B, 8'h9D, 8'h42};
  int d0;

  initial begin
    // Reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_err", 32'(err_overrun), 0);
    chk("rst_addr", 32'(write_address), 0);
    chk("rst_data", 32'(data_In), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("idle_no_ready", 32'(in_ready), 0);

    // Full sheet of 16-pixel runs of palette 3
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_in_ready", 32'(in_ready), 1);
    m_addr = 0; m_over = 1'b0; d0 = done_cnt;
    for (int i = 0; i < 2500; i++) send_byte(8'hF3, 1'b0);
    idle_src();
    wait_done(100);
    chk("t1_loaded_in_finish", 32'(loaded), 1);
    repeat (3) @(negedge Clk);
    chk("t1_done_count", 32'(done_cnt - d0), 1);
    chk("t1_loaded", 32'(loaded), 1);
    chk("t1_err", 32'(err_overrun), 0);
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_queue_empty", 32'(exp_q.size()), 0);
    chk("t1_model_addr", 32'(m_addr), NP);

    // Overrun at the last address, with an ignored start around address 1000
    pulse_start();
    chk("t3_loaded_cleared", 32'(loaded), 0);
    m_addr = 0; m_over = 1'b0; d0 = done_cnt;
    for (int i = 0; i < 2499; i++) begin
      if (i == 63) pulse_start();
      send_byte(8'hF3, 1'b0);
    end
    send_byte(8'hD3, 1'b0);
    chk("t3_model_at_39998", 32'(m_addr), NP - 2);
    send_byte(8'h47, 1'b0);
    idle_src();
    wait_done(100);
    repeat (3) @(negedge Clk);
    chk("t3_done_count", 32'(done_cnt - d0), 1);
    chk("t3_err", 32'(err_overrun), 1);
    chk("t3_model_over", 32'(m_over), 1);
    chk("t3_loaded", 32'(loaded), 1);
    chk("t3_queue_empty", 32'(exp_q.size()), 0);

    // Short runs with exactly one FETCH cycle between them
    pulse_start();
    chk("t2_err_cleared", 32'(err_overrun), 0);
    chk("t2_loaded_cleared", 32'(loaded), 0);
    m_addr = 0; m_over = 1'b0;
    send_byte(8'h20, 1'b0);
    push_byte(8'h05);
    @(negedge Clk);
    in_data = 8'h05; in_valid = 1'b1;
    chk("t2_addr0", 32'(write_address), 0);
    @(negedge Clk);
    chk("t2_addr1", 32'(write_address), 1);
    @(negedge Clk);
    chk("t2_addr2", 32'(write_address), 2);
    @(negedge Clk);
    chk("t2_fetch_we", 32'(we), 0);
    chk("t2_fetch_ready", 32'(in_ready), 1);
    @(negedge Clk);
    in_valid = 1'b0;
    chk("t2_we_addr3", 32'(we), 1);
    chk("t2_addr3", 32'(write_address), 3);
    chk("t2_data3", 32'(data_In), 5);

    // Same load continues with a randomly gated source
    for (int i = 0; i < 16; i++) send_byte(rnd_tab[i], 1'b1);
    idle_src();
    repeat (20) @(negedge Clk);
    chk("t4_queue_empty", 32'(exp_q.size()), 0);
    chk("t4_still_busy", 32'(busy), 1);

    // Asynchronous reset in the middle of a run
    send_byte(8'hF9, 1'b0);
    idle_src();
    chk("t6_mid_write", 32'(we), 1);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("t6_we_async", 32'(we), 0);
    chk("t6_busy_async", 32'(busy), 0);
    chk("t6_loaded_async", 32'(loaded), 0);
    chk("t6_ready_async", 32'(in_ready), 0);
    exp_q.delete();
    @(negedge Clk);
    Reset_n = 1'b1;
    pulse_start();
    m_addr = 0; m_over = 1'b0;
    send_byte(8'h1B, 1'b0);
    @(negedge Clk);
    in_valid = 1'b0;
    chk("t6_reload_addr0", 32'(write_address), 0);
    chk("t6_reload_data", 32'(data_In), 11);
    repeat (5) @(negedge Clk);
    chk("t6_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
